// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Op encodings, FSM states, icc bit positions.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_UMUL = 3'd0,
    MD_SMUL = 3'd1,
    MD_UDIV = 3'd2,
    MD_SDIV = 3'd3
  } mdop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdstate_e;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  function automatic logic is_div(mdop_e op);
    return (op == MD_UDIV) || (op == MD_SDIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One radix-2 iteration: shift-add for multiply,
// restoring shift-subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] mq_i,
  input  logic [XLEN-1:0] mcand_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] mq_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   sel;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] diff;
  logic            borrow;

  always_comb begin
    sum    = {1'b0, acc_i} + {1'b0, mcand_i};
    sel    = mq_i[0] ? sum : {1'b0, acc_i};
    shl    = {acc_i, mq_i[XLEN-1]};
    borrow = shl < {1'b0, mcand_i};
    // partial remainder stays below the divisor, so XLEN bits suffice
    diff   = shl[XLEN-1:0] - mcand_i;
    if (is_div) begin
      acc_o = borrow ? shl[XLEN-1:0] : diff;
      mq_o  = {mq_i[XLEN-2:0], ~borrow};
    end else begin
      acc_o = sel[XLEN:1];
      mq_o  = {sel[0], mq_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit with
// valid/ready handshakes, flush and sign fix-up.
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdop_e           in_op,
  input  logic            in_cc,
  input  logic [XLEN-1:0] in_valA,
  input  logic [XLEN-1:0] in_valB,
  input  logic [XLEN-1:0] in_Y,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [XLEN-1:0] out_Y,
  output logic            out_Y_write,
  output logic [3:0]      out_icc,
  output logic            out_icc_write,
  output logic [RD_W-1:0] out_rd,
  output logic            out_dz,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  mdstate_e        state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mq_q, mq_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  mdop_e           op_q, op_d;
  logic            cc_q, cc_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;
  logic            pend_q, pend_d;

  logic [XLEN-1:0]   st_acc, st_mq;
  logic              sgn_in;
  logic [XLEN-1:0]   a_mag, b_mag, dsr;
  logic [2*XLEN-1:0] dvd, dvd_mag;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div(op_q)),
    .acc_i  (acc_q),
    .mq_i   (mq_q),
    .mcand_i(mcand_q),
    .acc_o  (st_acc),
    .mq_o   (st_mq)
  );

  always_comb begin
    sgn_in  = (in_op == MD_SMUL) || (in_op == MD_SDIV);
    a_mag   = (sgn_in && in_valA[XLEN-1]) ? -in_valA : in_valA;
    b_mag   = (sgn_in && in_valB[XLEN-1]) ? -in_valB : in_valB;
    dsr     = b_mag;
    dvd     = {in_Y, in_valA};
    dvd_mag = (in_op == MD_SDIV && in_Y[XLEN-1]) ? -dvd : dvd;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    cc_d    = cc_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d    = in_op;
          cc_d    = in_cc;
          rd_d    = in_rd;
          cnt_d   = '0;
          dz_d    = 1'b0;
          pend_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_CALC;
          if (is_div(in_op)) begin
            acc_d   = dvd_mag[2*XLEN-1:XLEN];
            mq_d    = dvd_mag[XLEN-1:0];
            mcand_d = dsr;
            neg_d   = (in_op == MD_SDIV) &&
                      (in_Y[XLEN-1] ^ in_valB[XLEN-1]);
            // quotient cannot fit when the high half already >= divisor
            ovf_d   = dvd_mag[2*XLEN-1:XLEN] >= dsr;
            if (in_valB == '0) begin
              dz_d    = 1'b1;
              pend_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            acc_d   = '0;
            mq_d    = b_mag;
            mcand_d = a_mag;
            neg_d   = (in_op == MD_SMUL) &&
                      (in_valA[XLEN-1] ^ in_valB[XLEN-1]);
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = st_acc;
          mq_d  = st_mq;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush) state_d = ST_IDLE;
        else if (pend_q) pend_d = 1'b0;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      op_q    <= MD_UMUL;
      cc_q    <= 1'b0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      cc_q    <= cc_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      pend_q  <= pend_d;
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   q_neg, res, yv;
  logic              sat, v, ywr, vld;

  always_comb begin
    prod   = {acc_q, mq_q};
    prod_s = neg_q ? -prod : prod;
    q_neg  = -mq_q;
    sat    = ovf_q | (neg_q ? (mq_q[XLEN-1] & (|mq_q[XLEN-2:0]))
                            : mq_q[XLEN-1]);
    res    = '0;
    yv     = '0;
    v      = 1'b0;
    ywr    = 1'b0;
    unique case (1'b1)
      dz_q: res = '0;
      !dz_q && !is_div(op_q): begin
        res = prod_s[XLEN-1:0];
        yv  = prod_s[2*XLEN-1:XLEN];
        ywr = 1'b1;
      end
      !dz_q && op_q == MD_UDIV: begin
        res = ovf_q ? '1 : mq_q;
        v   = ovf_q;
      end
      !dz_q && op_q == MD_SDIV: begin
        v = sat;
        if (sat) res = neg_q ? {1'b1, {(XLEN-1){1'b0}}}
                             : {1'b0, {(XLEN-1){1'b1}}};
        else     res = neg_q ? q_neg : mq_q;
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    vld           = (state_q == ST_DONE) && !pend_q && !flush;
    in_ready      = state_q == ST_IDLE;
    busy          = state_q != ST_IDLE;
    out_valid     = vld;
    out_res       = vld ? res : '0;
    out_Y         = vld ? yv : '0;
    out_Y_write   = vld & ywr;
    out_rd        = vld ? rd_q : '0;
    out_dz        = vld & dz_q;
    out_icc_write = vld & cc_q & ~dz_q;
    out_icc       = '0;
    if (vld) begin
      out_icc[ICC_N] = res[XLEN-1];
      out_icc[ICC_Z] = res == '0;
      out_icc[ICC_V] = v;
      out_icc[ICC_C] = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed ops,
// hold/flush/reset scenarios, latency checks.
module tb_ex_muldiv_unit;
  import ex_muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int LAT  = XLEN + 1;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  mdop_e           in_op;
  logic            in_cc;
  logic [XLEN-1:0] in_valA, in_valB, in_Y;
  logic [RD_W-1:0] in_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_res, out_Y;
  logic            out_Y_write;
  logic [3:0]      out_icc;
  logic            out_icc_write;
  logic [RD_W-1:0] out_rd;
  logic            out_dz;
  logic            busy;

  ex_muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cc(in_cc),
    .in_valA(in_valA), .in_valB(in_valB),
    .in_Y(in_Y), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_Y(out_Y),
    .out_Y_write(out_Y_write), .out_icc(out_icc),
    .out_icc_write(out_icc_write), .out_rd(out_rd),
    .out_dz(out_dz), .busy(busy)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] y;
    logic            ywr;
    logic [3:0]      icc;
    logic            iccwr;
    logic [RD_W-1:0] rd;
    logic            dz;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks;
  int   failures;
  int   cyc;
  bit   seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [XLEN-1:0] res,
                              input logic [XLEN-1:0] y,
                              input logic ywr, input logic [3:0] icc,
                              input logic iccwr, input logic dz);
    exp_t x;
    x.res = res; x.y = y; x.ywr = ywr; x.icc = icc;
    x.iccwr = iccwr; x.dz = dz; x.rd = '0; x.cyc = 0;
    return x;
  endfunction

  always @(negedge clk) begin
    if (out_valid && !seen) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid res=%0h", out_res);
      end else begin
        mon_e = sb.pop_front();
        chk("res", out_res, mon_e.res);
        chk("y", out_Y, mon_e.y);
        chk("y_write", out_Y_write, mon_e.ywr);
        chk("icc", out_icc, mon_e.icc);
        chk("icc_write", out_icc_write, mon_e.iccwr);
        chk("rd", out_rd, mon_e.rd);
        chk("dz", out_dz, mon_e.dz);
        chk("latency_cycle", cyc, mon_e.cyc);
      end
    end
    seen = out_valid;
  end

  task automatic issue(input mdop_e op, input logic cc,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] y, input logic [RD_W-1:0] rd,
                       input bit push, input exp_t e, input int lat);
    int n;
    exp_t x;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_wait in_ready=%0b expected=1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_cc = cc;
    in_valA = a; in_valB = b; in_Y = y; in_rd = rd;
    @(negedge clk);
    x = e;
    x.rd = rd;
    x.cyc = cyc + lat;
    if (push) sb.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; seen = 0;
    reset = 1'b0; in_valid = 1'b0; in_op = MD_UMUL; in_cc = 1'b0;
    in_valA = '0; in_valB = '0; in_Y = '0; in_rd = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_y_write", out_Y_write, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(MD_UMUL, 0, 32'hFFFFFFFF, 32'h2, 0, 5'd1, 1,
          mk(32'hFFFFFFFE, 32'h1, 1, 4'b1000, 0, 0), LAT);
    drain();
    issue(MD_SMUL, 1, 32'hFFFFFFFD, 32'd7, 0, 5'd2, 1,
          mk(32'hFFFFFFEB, 32'hFFFFFFFF, 1, 4'b1000, 1, 0), LAT);
    drain();
    issue(MD_SMUL, 1, 32'd0, 32'd5, 0, 5'd3, 1,
          mk(32'h0, 32'h0, 1, 4'b0100, 1, 0), LAT);
    drain();
    issue(MD_UDIV, 1, 32'd0, 32'd1, 32'd1, 5'd4, 1,
          mk(32'hFFFFFFFF, 32'h0, 0, 4'b1010, 1, 0), LAT);
    drain();
    issue(MD_SDIV, 1, 32'd100, 32'hFFFFFFF9, 32'd0, 5'd5, 1,
          mk(32'hFFFFFFF2, 32'h0, 0, 4'b1000, 1, 0), LAT);
    drain();
    issue(MD_UDIV, 0, 32'd100, 32'd7, 32'd0, 5'd6, 1,
          mk(32'hE, 32'h0, 0, 4'b0000, 0, 0), LAT);
    drain();
    issue(MD_SDIV, 1, 32'h80000000, 32'd1, 32'd0, 5'd7, 1,
          mk(32'h7FFFFFFF, 32'h0, 0, 4'b0010, 1, 0), LAT);
    drain();
    issue(MD_SDIV, 1, 32'h80000000, 32'd1, 32'hFFFFFFFF, 5'd8, 1,
          mk(32'h80000000, 32'h0, 0, 4'b1000, 1, 0), LAT);
    drain();
    issue(MD_UDIV, 1, 32'd55, 32'd0, 32'd0, 5'd9, 1,
          mk(32'h0, 32'h0, 0, 4'b0100, 0, 1), 2);
    drain();
    issue(MD_SDIV, 1, 32'd55, 32'd0, 32'd3, 5'd10, 1,
          mk(32'h0, 32'h0, 0, 4'b0100, 0, 1), 2);
    drain();

    issue(MD_UMUL, 0, 32'd3, 32'd5, 0, 5'd11, 1,
          mk(32'hF, 32'h0, 1, 4'b0000, 0, 0), LAT);
    issue(MD_UMUL, 1, 32'h10000, 32'h10000, 0, 5'd12, 1,
          mk(32'h0, 32'h1, 1, 4'b0100, 1, 0), LAT);
    drain();

    out_ready = 1'b0;
    issue(MD_UMUL, 0, 32'd7, 32'd6, 0, 5'd13, 1,
          mk(32'h2A, 32'h0, 1, 4'b0000, 0, 0), LAT);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_res", out_res, 32'h2A);
      chk("hold_rd", out_rd, 13);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    issue(MD_UMUL, 0, 32'd9, 32'd9, 0, 5'd14, 0,
          mk(32'h0, 32'h0, 0, 4'b0000, 0, 0), LAT);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc_in_ready", in_ready, 1);
    chk("flush_calc_busy", busy, 0);
    chk("flush_calc_valid", out_valid, 0);
    repeat (40) @(posedge clk);
    #1;

    flush = 1'b1; in_valid = 1'b1; in_op = MD_UMUL;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_busy", busy, 0);

    out_ready = 1'b0;
    issue(MD_UMUL, 0, 32'd2, 32'd3, 0, 5'd15, 1,
          mk(32'h6, 32'h0, 1, 4'b0000, 0, 0), LAT);
    wait_valid();
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_done_valid", out_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_in_ready", in_ready, 1);
    chk("flush_done_valid_after", out_valid, 0);

    issue(MD_UMUL, 0, 32'd11, 32'd13, 0, 5'd16, 0,
          mk(32'h0, 32'h0, 0, 4'b0000, 0, 0), LAT);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_res", out_res, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_in_ready", in_ready, 1);
    issue(MD_SMUL, 1, 32'hFFFFFFFD, 32'hFFFFFFFD, 0, 5'd17, 1,
          mk(32'h9, 32'h0, 1, 4'b0000, 1, 0), LAT);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal values 16, 32, 64.
REQ-002 Parameter RD_W, default 5: destination register tag width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  unit can accept; high only in IDLE.
REQ-007 in_op  input  3  mdop_e: UMUL, SMUL, UDIV, SDIV.
REQ-008 in_cc  input  1  operation also writes icc.
REQ-009 in_valA, in_valB  input  XLEN each  rs1 and rs2/simm operand (already muxed).
REQ-010 in_Y  input  XLEN  current Y register; upper dividend half for divides.
REQ-011 in_rd  input  RD_W  destination tag, carried through.
REQ-012 flush  input  1  annul/branch kill of the in-flight operation.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  memory stage accepts the result (mem_ready).
REQ-015 out_res  output  XLEN  result low half or quotient.
REQ-016 out_Y / out_Y_write  output  XLEN / 1  product high half; write strobe.
REQ-017 out_icc / out_icc_write  output  4 / 1  {N,Z,V,C}; write strobe equals latched in_cc.
REQ-018 out_rd / out_dz  output  RD_W / 1  destination tag; divide-by-zero trap flag.
REQ-019 busy  output  1  high in CALC or DONE; drives decode stall.

Function
REQ-020 The FSM SHALL have states IDLE, CALC, DONE.
REQ-021 IDLE: in_valid & !flush -> latch operands, op, cc, rd; go CALC, or go DONE if divide with in_valB==0.
REQ-022 CALC SHALL run exactly XLEN iterations via a log2(XLEN)+1-bit counter, then go DONE.
REQ-023 Multiply: radix-2 shift-add on magnitudes; signed result negated when operand signs differ; 2*XLEN product split into out_Y (high) and out_res (low).
REQ-024 Divide: dividend {Y,valA}; restoring division on magnitudes; quotient only, remainder discarded.
REQ-025 UDIV overflow: Y >= divisor detected at accept; result SHALL be all-ones, V=1.
REQ-026 SDIV overflow: result SHALL saturate to 0x7F..F (positive) or 0x80..0 (negative), V=1.
REQ-027 Divide-by-zero: out_dz=1, out_res=0, out_icc_write=0, out_Y_write=0; latency 2 cycles.
REQ-028 icc: N=out_res[XLEN-1], Z=(out_res==0), V per REQ-025/026 (0 for multiply), C=0.
REQ-029 out_Y_write SHALL be 1 for multiplies, 0 for divides.
REQ-030 DONE: out_valid=1; outputs held stable until out_ready; out_ready -> IDLE.
REQ-031 Latency: accept in cycle N, out_valid first in cycle N+XLEN+1; throughput one op per XLEN+2 cycles.
REQ-032 flush in CALC or DONE SHALL return to IDLE next cycle with no out_valid; flush in IDLE blocks acceptance that cycle.
REQ-033 flush and out_ready together in DONE: flush wins; result SHALL NOT be marked consumed.
REQ-034 in_ready SHALL be combinational from state only, never from in_valid.

Reset
REQ-035 Reset asserted: state IDLE, counter 0, all datapath registers 0, out_valid=0, busy=0, all strobes 0.
REQ-036 Reset mid-CALC SHALL abort the operation immediately; in_ready=1 on the first edge after deassertion.

Structure
REQ-037 Package ex_muldiv_pkg SHALL hold mdop_e, mdstate_e and icc bit-index constants.
REQ-038 One sub-module, muldiv_step, SHALL implement a single shift-add/shift-subtract iteration; the FSM, counter and sign fix-up stay in the top.

Verification
REQ-039 UMUL 0xFFFFFFFF*2 -> out_res 0xFFFFFFFE, out_Y 0x1, out_Y_write=1, out_valid at cycle N+33.
REQ-040 SMUL -3*7 with cc -> out_res 0xFFFFFFEB, out_Y 0xFFFFFFFF, icc N=1 Z=0 V=0 C=0.
REQ-041 UDIV Y=0x1, valA=0, valB=0x1 -> out_res 0xFFFFFFFF, V=1; SDIV Y=0, valA=100, valB=-7 -> out_res 0xFFFFFFF2.
REQ-042 UDIV valB=0 -> out_dz=1, out_valid at N+2, both write strobes 0.
REQ-043 out_ready held low 5 cycles in DONE -> outputs constant and in_ready=0; flush asserted at CALC iteration 10 -> no out_valid, in_ready=1 next cycle.
REQ-044 reset pulsed during CALC -> all outputs 0 immediately; next op completes correctly.
